sys_timer_arbiter: RTL and testbench
====================================

// Module: sys_timer_arbiter
// PURPOSE
//  Shares the single 32-bit system-timer read port (CYCLE/TIME/INSTRET, half-select) between two
//  requesters: the core CSR path (port 0) and the MMIO bus bridge (port 1). A lower-half read runs
//  an H1->L->H2 sequence that retries on carry, so lower+upper reads form one coherent 64-bit value.
//  The coherent upper half is held in a per-requester shadow and returned by that requester's next
//  upper read. Sits between the CSR unit / bus slave and the system timer.
// PARAMETERS
//  MAX_RETRY  3   L/H2 re-reads allowed after an H1!=H2 mismatch before the last sample is accepted
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req[1:0]     in   2   read request per port (0=core, 1=bus); held high until ack
//  timer0/1     in   2   timer select per port: 0=CYCLE, 1=TIME, 2=INSTRET, 3=illegal
//  upper0/1     in   1   1 = upper 32 bits, 0 = lower 32 bits
//  ack[1:0]     out  2   one-cycle pulse; rdata valid on the same cycle
//  rdata0/1     out  32  read data per port
//  tmr_sel      out  2   timer select to system timer
//  tmr_upper    out  1   half select to system timer
//  tmr_data     in   32  combinational timer read data for tmr_sel/tmr_upper
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; ack=0; rdata0/1=0; tmr_sel=0; tmr_upper=0; retry=0;
//    last_grant=1 (so port 0 wins first); both shadows invalid. Reset mid-sequence aborts with no ack.
//    A request still held after reset is re-arbitrated from IDLE.
//  FSM: IDLE, RD_H1, RD_L, RD_H2, RD_U, ACK. tmr_sel/tmr_upper are registered from the latched
//    request; tmr_data is sampled at the edge ending each RD_* state.
//  Arbitration, IDLE only: one request -> grant it. Both -> grant !last_grant (round-robin).
//    Latch timer/upper/port on grant and update last_grant. A non-granted request waits; it is
//    never dropped.
//  Lower read: IDLE(grant, cycle n) -> RD_H1 (n+1, upper=1) -> RD_L (n+2, upper=0)
//    -> RD_H2 (n+3, upper=1) -> ACK (n+4). ack and rdata=L are issued at n+4.
//  Carry retry: in RD_H2, if H2!=H1 and retry<MAX_RETRY, set H1:=H2, retry++ and go to RD_L.
//    Each retry adds 2 cycles. If H2==H1, or retry==MAX_RETRY, accept L and store H2 in the
//    granted port's shadow (shadow_hi, shadow_timer, valid=1). retry clears on entry to ACK.
//  Upper read, shadow valid and shadow_timer==timer:
//    IDLE -> ACK (ack at n+1); rdata=shadow_hi; shadow invalidated.
//  Upper read, otherwise: IDLE -> RD_U (n+1, upper=1) -> ACK (n+2); rdata=tmr_data sample;
//    shadow unchanged.
//  Illegal timer (3): IDLE -> ACK at n+1, rdata=0, no timer access, shadows unchanged.
//  ACK -> IDLE unconditionally, so back-to-back service is possible. The requester must drop req
//    the cycle after ack. A req still high in IDLE is treated as a new request.
//  Shadows are per port. Port 1 activity never reads, writes or invalidates the port 0 shadow,
//    and vice versa. A lower read overwrites the shadow even if it is already valid.
//  rdata of a port holds its last value between acks. No other outputs are combinational on
//    inputs.
// TESTING
//  1. Lower CYCLE read, port0, timer lo=0x10, hi=0x2 static -> ack0 at n+4, rdata0=0x10;
//     next upper read -> ack0 at n+1, rdata0=0x2.
//  2. Carry: hi=0x1 during H1 and L=0xFFFFFFFF; then lo=0x00000003, hi=0x2 for the retry
//     -> one retry, ack0 at n+6, rdata0=0x3, then upper rdata0=0x2.
//  3. Persistent mismatch (hi changes every sample), MAX_RETRY=3 -> ack at n+10 and the
//     last L/H2 are accepted.
//  4. req=2'b11 held continuously -> grants alternate 0,1,0,1; no starvation; port1 upper read
//     with no shadow takes the RD_U path (ack at n+2).
//  5. timer0=3 -> ack0 at n+1, rdata0=0, tmr_sel stays at its previous value.
//  6. rst_n low during RD_L -> ack stays 0, shadows invalid; after release the held req restarts
//     the sequence from IDLE and completes normally.

Source files
------------

// File: rtl/sys_timer_arbiter.sv
// Two-port arbiter for the 32-bit system-timer read port. Lower-half reads run a
// carry-safe H1/L/H2 sequence and park the coherent upper half in a per-port shadow.
module sys_timer_arbiter #(
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  timer0,
  input  logic [1:0]  timer1,
  input  logic        upper0,
  input  logic        upper1,
  output logic [1:0]  ack,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [1:0]  tmr_sel,
  output logic        tmr_upper,
  input  logic [31:0] tmr_data
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, RD_H1, RD_L, RD_H2, RD_U, ACK} state_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic          port_q;
  logic [1:0]    timer_q;
  logic [RW-1:0] retry;
  logic [31:0]   h1;
  logic [31:0]   lo;
  logic [31:0]   rdata_q      [2];
  logic [31:0]   shadow_hi    [2];
  logic [1:0]    shadow_timer [2];
  logic [1:0]    shadow_valid;

  logic          any_req;
  logic          grant;
  logic [1:0]    grant_timer;
  logic          grant_upper;
  logic          shadow_hit;
  logic          h_match;
  logic          retry_done;

  // Round-robin only matters when both ports ask at once.
  always_comb begin
    any_req     = |req;
    grant       = (req == 2'b11) ? ~last_grant : req[1];
    grant_timer = grant ? timer1 : timer0;
    grant_upper = grant ? upper1 : upper0;
    shadow_hit  = shadow_valid[grant] && (shadow_timer[grant] == grant_timer);
    h_match     = (tmr_data == h1);
    retry_done  = (retry == RW'(MAX_RETRY));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (grant_timer == 2'd3)              state_nxt = ACK;
          else if (grant_upper && shadow_hit)   state_nxt = ACK;
          else if (grant_upper)                 state_nxt = RD_U;
          else                                  state_nxt = RD_H1;
        end
      end
      RD_H1:   state_nxt = RD_L;
      RD_L:    state_nxt = RD_H2;
      RD_H2:   state_nxt = (!h_match && !retry_done) ? RD_L : ACK;
      RD_U:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack = 2'b00;
    if (state == ACK) ack[port_q] = 1'b1;
  end

  // Datapath: tmr_sel/tmr_upper are set one cycle ahead so each RD_* state sees a stable select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant      <= 1'b1;
      port_q          <= 1'b0;
      timer_q         <= 2'd0;
      retry           <= '0;
      h1              <= 32'h0;
      lo              <= 32'h0;
      rdata_q[0]      <= 32'h0;
      rdata_q[1]      <= 32'h0;
      shadow_hi[0]    <= 32'h0;
      shadow_hi[1]    <= 32'h0;
      shadow_timer[0] <= 2'd0;
      shadow_timer[1] <= 2'd0;
      shadow_valid    <= 2'b00;
      tmr_sel         <= 2'd0;
      tmr_upper       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            port_q     <= grant;
            timer_q    <= grant_timer;
            last_grant <= grant;
            if (grant_timer == 2'd3) begin
              rdata_q[grant] <= 32'h0;
            end else if (grant_upper && shadow_hit) begin
              rdata_q[grant]      <= shadow_hi[grant];
              shadow_valid[grant] <= 1'b0;
            end else begin
              tmr_sel   <= grant_timer;
              tmr_upper <= 1'b1;
            end
          end
        end
        RD_H1: begin
          h1        <= tmr_data;
          tmr_upper <= 1'b0;
        end
        RD_L: begin
          lo        <= tmr_data;
          tmr_upper <= 1'b1;
        end
        RD_H2: begin
          if (!h_match && !retry_done) begin
            h1        <= tmr_data;
            retry     <= retry + RW'(1);
            tmr_upper <= 1'b0;
          end else begin
            rdata_q[port_q]      <= lo;
            shadow_hi[port_q]    <= tmr_data;
            shadow_timer[port_q] <= timer_q;
            shadow_valid[port_q] <= 1'b1;
            retry                <= '0;
          end
        end
        RD_U: begin
          rdata_q[port_q] <= tmr_data;
        end
        default: ;
      endcase
    end
  end

  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

endmodule

// File: tb/tb_sys_timer_arbiter.sv
// Randomized self-checking bench for sys_timer_arbiter: a cycle-indexed history of three
// 64-bit timers feeds a transaction-level model of the coherent-read and shadow rules.
module tb_sys_timer_arbiter;

  localparam int MAXR = 3;
  localparam int HLEN = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  timer0, timer1;
  logic        upper0, upper1;
  logic [1:0]  ack;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  tmr_sel;
  logic        tmr_upper;
  logic [31:0] tmr_data;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          load_cyc = -1;
  int          load_sel = 0;
  logic [63:0] load_val = 64'h0;
  logic [63:0] step = 64'h0;
  bit          pending_load = 1'b0;
  int          last_lat = 0;

  logic [63:0] cnt  [3];
  logic [63:0] hist [3][0:HLEN-1];
  int          sel_idx;

  bit          m_last;
  bit          m_sv   [2];
  logic [31:0] m_sh   [2];
  logic [1:0]  m_st   [2];
  logic [1:0]  m_tsel;
  logic [31:0] m_rdata[2];

  sys_timer_arbiter #(.MAX_RETRY(MAXR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .timer0    (timer0),
    .timer1    (timer1),
    .upper0    (upper0),
    .upper1    (upper1),
    .ack       (ack),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .tmr_sel   (tmr_sel),
    .tmr_upper (tmr_upper),
    .tmr_data  (tmr_data)
  );

  always #5 clk = ~clk;

  // Timer source: hist[t][c] is the value every timer shows during cycle c.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      cnt[i] <= !rst_n ? (64'(i) << 32) :
                (cyc == load_cyc && load_sel == i) ? load_val : cnt[i] + step;
      if (cyc < HLEN - 1)
        hist[i][cyc+1] <= !rst_n ? (64'(i) << 32) :
                          (cyc == load_cyc && load_sel == i) ? load_val : cnt[i] + step;
    end
    cyc <= cyc + 1;
  end

  assign sel_idx  = (tmr_sel == 2'd3) ? 0 : int'(tmr_sel);
  assign tmr_data = tmr_upper ? cnt[sel_idx][63:32] : cnt[sel_idx][31:0];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic resetModel();
    m_last = 1'b1;
    m_tsel = 2'd0;
    for (int p = 0; p < 2; p++) begin
      m_sv[p] = 1'b0; m_sh[p] = 32'h0; m_st[p] = 2'd0; m_rdata[p] = 32'h0;
    end
  endtask

  // Reference: what the requester should see for a grant in cycle n, from the timer history.
  task automatic modelTxn(input int port, input int n, output int lat, output logic [31:0] data);
    int tsel, t, r;
    logic up;
    logic [31:0] h1, h2, l;
    tsel   = int'(port ? timer1 : timer0);
    up     = port ? upper1 : upper0;
    m_last = port[0];
    if (tsel == 3) begin
      lat = 1; data = 32'h0;
    end else if (up && m_sv[port] && m_st[port] == 2'(tsel)) begin
      lat = 1; data = m_sh[port]; m_sv[port] = 1'b0;
    end else if (up) begin
      lat = 2; data = hist[tsel][n+1][63:32]; m_tsel = 2'(tsel);
    end else begin
      h1 = hist[tsel][n+1][63:32];
      l  = hist[tsel][n+2][31:0];
      h2 = hist[tsel][n+3][63:32];
      t  = n + 3;
      r  = 0;
      while (h2 !== h1 && r < MAXR) begin
        h1 = h2;
        l  = hist[tsel][t+1][31:0];
        h2 = hist[tsel][t+2][63:32];
        t += 2;
        r++;
      end
      lat = t + 1 - n;
      data = l;
      m_sv[port] = 1'b1; m_sh[port] = h2; m_st[port] = 2'(tsel); m_tsel = 2'(tsel);
    end
    m_rdata[port] = data;
  endtask

  task automatic serviceOne(input int n, input int g);
    bit got;
    int lat;
    logic [31:0] data;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (ack != 2'b00) got = 1'b1;
    end
    checkOutput("ack_seen", 64'(got), 64'd1);
    modelTxn(g, n, lat, data);
    last_lat = cyc - n;
    checkOutput("ack_vec", 64'(ack), 64'(2'b01 << g));
    checkOutput("latency", 64'(cyc - n), 64'(lat));
    checkOutput("rdata", 64'(g ? rdata1 : rdata0), 64'(data));
    checkOutput("rdata_hold", 64'(g ? rdata0 : rdata1), 64'(m_rdata[1-g]));
    checkOutput("tmr_sel", 64'(tmr_sel), 64'(m_tsel));
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input int count);
    int n, g;
    @(negedge clk);
    req = mask;
    n = cyc;
    if (pending_load) begin
      load_cyc = n;
      pending_load = 1'b0;
    end
    for (int s = 0; s < count; s++) begin
      g = (mask == 2'b11) ? int'(!m_last) : int'(mask[1]);
      serviceOne(n, g);
      n = cyc + 1;
    end
    req = 2'b00;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = 2'b00;
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", 64'(ack), 64'd0);
    checkOutput("rst_rdata0", 64'(rdata0), 64'd0);
    checkOutput("rst_rdata1", 64'(rdata1), 64'd0);
    checkOutput("rst_tmr_sel", 64'(tmr_sel), 64'd0);
    checkOutput("rst_tmr_upper", 64'(tmr_upper), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = 2'b00;
    timer0 = 2'd0; timer1 = 2'd0; upper0 = 1'b0; upper1 = 1'b0;
    doReset();

    // Static CYCLE value: plain lower read then shadow hit.
    step = 64'h0; load_sel = 0; load_val = 64'h2_0000_0010; pending_load = 1'b1;
    timer0 = 2'd0; upper0 = 1'b0;
    applyStimulus(2'b01, 1);
    checkOutput("t1_lo", 64'(rdata0), 64'h10);
    checkOutput("t1_lat", 64'(last_lat), 64'd4);
    upper0 = 1'b1;
    applyStimulus(2'b01, 1);
    checkOutput("t1_hi", 64'(rdata0), 64'h2);
    checkOutput("t1_hi_lat", 64'(last_lat), 64'd1);

    // Carry between H1 and H2 forces exactly one retry.
    step = 64'd2; load_sel = 0; load_val = 64'h1_FFFF_FFFD; pending_load = 1'b1;
    upper0 = 1'b0;
    applyStimulus(2'b01, 1);
    checkOutput("t2_lo", 64'(rdata0), 64'h3);
    checkOutput("t2_lat", 64'(last_lat), 64'd6);
    upper0 = 1'b1;
    applyStimulus(2'b01, 1);
    checkOutput("t2_hi", 64'(rdata0), 64'h2);

    // Upper half moves every cycle: retries run out.
    step = 64'h1_0000_0001;
    timer1 = 2'd1; upper1 = 1'b0;
    applyStimulus(2'b10, 1);
    checkOutput("t3_lat", 64'(last_lat), 64'd10);

    // Illegal timer select.
    step = 64'd1;
    timer0 = 2'd3; upper0 = 1'b0;
    applyStimulus(2'b01, 1);
    checkOutput("t5_rdata", 64'(rdata0), 64'h0);
    checkOutput("t5_lat", 64'(last_lat), 64'd1);
    checkOutput("t5_tmr_sel", 64'(tmr_sel), 64'd1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: step = 64'h0;
        1: step = 64'($urandom_range(1, 8));
        2: step = 64'h1_0000_0000 + 64'($urandom_range(0, 3));
        default: step = {32'h0, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) begin
        load_sel = $urandom_range(0, 2);
        load_val = {32'($urandom_range(0, 5)), 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
        pending_load = 1'b1;
      end
      timer0 = 2'($urandom_range(0, 3)); upper0 = 1'($urandom_range(0, 1));
      timer1 = 2'($urandom_range(0, 3)); upper1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) applyStimulus(2'b11, 2);
      else if ($urandom_range(0, 1) == 0) applyStimulus(2'b01, 1);
      else applyStimulus(2'b10, 1);
    end

    // Both ports held: strict alternation, port 1 upper reads go through RD_U.
    doReset();
    step = 64'($urandom_range(1, 4));
    timer0 = 2'd0; upper0 = 1'b0; timer1 = 2'd1; upper1 = 1'b1;
    applyStimulus(2'b11, 6);
    checkOutput("t4_last_lat", 64'(last_lat), 64'd2);

    // Reset in the middle of a lower read.
    timer1 = 2'd2; upper1 = 1'b0;
    applyStimulus(2'b10, 1);
    @(negedge clk);
    timer0 = 2'd0; upper0 = 1'b0; req = 2'b01;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("t6_rst_ack", 64'(ack), 64'd0);
    checkOutput("t6_rst_rdata1", 64'(rdata1), 64'd0);
    @(negedge clk);
    checkOutput("t6_rst_ack2", 64'(ack), 64'd0);
    rst_n = 1'b1;
    n = cyc;
    serviceOne(n, 0);
    checkOutput("t6_restart_lat", 64'(last_lat), 64'd4);
    req = 2'b00;
    upper1 = 1'b1;
    applyStimulus(2'b10, 1);
    checkOutput("t6_no_shadow_lat", 64'(last_lat), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
